// File: rtl/upsample_interp.sv
// Streaming upsampler: repeats (nearest) or linearly interpolates (linear)
// each packed multi-lane Q8.8 input sample into UP_FACTOR output beats.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | collecting sample(s) needed before the next output phase run
// EMIT  | driving UP_FACTOR beats for the current sample
// DONE  | one-cycle completion pulse
module upsample_interp #(
  parameter int DATA_WIDTH = 16,
  parameter int CHANNELS   = 4,
  parameter int IN_LEN     = 8,
  parameter int UP_FACTOR  = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           mode,
  input  logic [CHANNELS*DATA_WIDTH-1:0] s_data,
  input  logic                           s_valid,
  output logic                           s_ready,
  output logic [CHANNELS*DATA_WIDTH-1:0] m_data,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic                           m_last,
  output logic                           busy,
  output logic                           done
);

  localparam int LOG2F = $clog2(UP_FACTOR);
  localparam int PW    = DATA_WIDTH + 1 + LOG2F;
  localparam int CW    = $clog2(IN_LEN + 1);
  localparam logic [LOG2F-1:0] KMAX = LOG2F'(UP_FACTOR - 1);
  localparam logic [CW-1:0]    LAST = CW'(IN_LEN - 1);
  localparam logic [CW-1:0]    LEN  = CW'(IN_LEN);

  typedef enum logic [1:0] {IDLE, LOAD, EMIT, DONE} state_t;

  state_t                          state;
  logic                            mode_q;
  logic [CHANNELS*DATA_WIDTH-1:0]  cur, nxt;
  logic [CW-1:0]                   in_cnt, smp_cnt;
  logic [LOG2F-1:0]                k;
  logic [CHANNELS*DATA_WIDTH-1:0]  interp;
  logic                            last_phase;

  // Per-lane interpolation: cur + floor((nxt-cur)*k / UP_FACTOR).
  // The result always lies between cur and nxt, so truncating to
  // DATA_WIDTH bits is exact.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    logic signed [DATA_WIDTH-1:0] cs, ns;
    logic signed [DATA_WIDTH:0]   diff;
    logic signed [PW-1:0]         prod, shf;
    assign cs   = cur[c*DATA_WIDTH +: DATA_WIDTH];
    assign ns   = nxt[c*DATA_WIDTH +: DATA_WIDTH];
    assign diff = {ns[DATA_WIDTH-1], ns} - {cs[DATA_WIDTH-1], cs};
    // low PW bits of the product do not depend on operand signedness
    assign prod = {{LOG2F{diff[DATA_WIDTH]}}, diff} * {{(PW-LOG2F){1'b0}}, k};
    assign shf  = prod >>> LOG2F;
    assign interp[c*DATA_WIDTH +: DATA_WIDTH] = mode_q ? (cs + shf[DATA_WIDTH-1:0]) : cs;
  end

  // Output decode from state; data regs do not move while stalled, so
  // m_data/m_last stay stable until the beat is taken.
  always_comb begin
    last_phase = (state == EMIT) && m_ready && (k == KMAX);
    m_valid    = (state == EMIT);
    m_data     = (state == EMIT) ? interp : '0;
    m_last     = (state == EMIT) && (k == KMAX) && (smp_cnt == LAST);
    busy       = (state == LOAD) || (state == EMIT);
    done       = (state == DONE);
    s_ready    = (state == LOAD) ||
                 (last_phase && (smp_cnt != LAST) && (in_cnt < LEN));
  end

  // Frame sequencing, sample buffering and phase counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mode_q  <= 1'b0;
      cur     <= '0;
      nxt     <= '0;
      in_cnt  <= '0;
      smp_cnt <= '0;
      k       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mode_q  <= mode;
            in_cnt  <= '0;
            smp_cnt <= '0;
            k       <= '0;
            state   <= LOAD;
          end
        end
        LOAD: begin
          if (s_valid) begin
            in_cnt <= in_cnt + CW'(1);
            k      <= '0;
            if (!mode_q) begin
              cur   <= s_data;
              state <= EMIT;
            end else if (in_cnt == '0) begin
              cur <= s_data;
              if (IN_LEN == 1) begin
                nxt   <= s_data;
                state <= EMIT;
              end
            end else begin
              nxt   <= s_data;
              state <= EMIT;
            end
          end
        end
        EMIT: begin
          if (m_ready) begin
            k <= k + LOG2F'(1);
            if (k == KMAX) begin
              smp_cnt <= smp_cnt + CW'(1);
              if (smp_cnt == LAST) begin
                state <= DONE;
              end else if (in_cnt < LEN) begin
                if (s_valid) begin
                  in_cnt <= in_cnt + CW'(1);
                  if (mode_q) begin
                    cur <= nxt;
                    nxt <= s_data;
                  end else begin
                    cur <= s_data;
                  end
                end else begin
                  state <= LOAD;
                  if (mode_q) cur <= nxt;
                end
              end else begin
                // inputs exhausted: final sample is held (nxt == cur)
                cur <= nxt;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_upsample_interp.sv
// Directed bench for upsample_interp (2 lanes, IN_LEN=4, UP_FACTOR=4) plus
// a second IN_LEN=1 instance for the single-sample linear case.
module tb_upsample_interp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, mode, s_valid, m_ready;
  logic [31:0] s_data;
  logic        s_ready, m_valid, m_last, busy, done;
  logic [31:0] m_data;

  logic        start1, mode1, s_valid1, m_ready1;
  logic [31:0] s_data1;
  logic        s_ready1, m_valid1, m_last1, busy1, done1;
  logic [31:0] m_data1;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] in_vec [4];
  logic [31:0] exp_vec[16];

  always #5 clk = ~clk;

  upsample_interp #(.DATA_WIDTH(16), .CHANNELS(2), .IN_LEN(4), .UP_FACTOR(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .busy(busy), .done(done));

  upsample_interp #(.DATA_WIDTH(16), .CHANNELS(2), .IN_LEN(1), .UP_FACTOR(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .mode(mode1),
    .s_data(s_data1), .s_valid(s_valid1), .s_ready(s_ready1),
    .m_data(m_data1), .m_valid(m_valid1), .m_ready(m_ready1), .m_last(m_last1),
    .busy(busy1), .done(done1));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One frame: md=mode, rnd=random stalls on both sides, pulse=start pulsed
  // mid-frame, abort_at>=0 asserts reset once that many beats were taken.
  task automatic run_frame(input bit md, input bit rnd, input bit pulse, input int abort_at);
    int idx = 0, beat = 0, cyc = 0;
    int acc_cyc[4];
    int first_cyc = -1, last_cyc = -1;
    bit prev_stall = 0;
    logic [31:0] prev_data = '0;
    logic        prev_last = 1'b0;
    @(negedge clk); start = 1'b1; mode = md;
    @(negedge clk); start = 1'b0; mode = ~md;
    while (beat < 16 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (abort_at >= 0 && beat == abort_at) begin
        rst_n = 1'b0;
        #1;
        check("abort m_valid", {31'b0, m_valid}, 32'd0);
        check("abort m_data", m_data, 32'd0);
        check("abort ctl", {28'b0, s_ready, m_last, busy, done}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        s_valid = 1'b0; m_ready = 1'b0;
        return;
      end
      start   = pulse && (cyc == 6);
      s_valid = (idx < 4) && (!rnd || $urandom_range(0, 3) != 0);
      s_data  = (idx < 4) ? in_vec[idx] : 32'hDEAD_BEEF;
      m_ready = !rnd || ($urandom_range(0, 2) != 0);
      #1;
      if (prev_stall) begin
        check("stall m_valid", {31'b0, m_valid}, 32'd1);
        check("stall m_data", m_data, prev_data);
        check("stall m_last", {31'b0, m_last}, {31'b0, prev_last});
      end
      if (m_valid && m_ready) begin
        if (beat == 0) begin
          first_cyc = cyc;
          check("busy in emit", {31'b0, busy}, 32'd1);
        end
        last_cyc = cyc;
        check($sformatf("beat%0d data", beat), m_data, exp_vec[beat]);
        check($sformatf("beat%0d last", beat), {31'b0, m_last}, {31'b0, beat == 15});
        beat++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      if (s_valid && s_ready) begin
        acc_cyc[idx] = cyc;
        idx++;
      end
    end
    start = 1'b0; s_valid = 1'b0;
    if (beat < 16) check("frame timeout beats", beat, 16);
    if (!rnd) begin
      check("no bubbles", last_cyc - first_cyc, 15);
      check("first beat latency", first_cyc - acc_cyc[md ? 1 : 0], 1);
    end
    @(negedge clk); #1;
    check("done pulse", {31'b0, done}, 32'd1);
    check("m_valid after frame", {31'b0, m_valid}, 32'd0);
    @(negedge clk); #1;
    check("done cleared", {30'b0, done, busy}, 32'd0);
    m_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 0; mode = 0; s_valid = 0; m_ready = 0; s_data = '0;
    start1 = 0; mode1 = 0; s_valid1 = 0; m_ready1 = 0; s_data1 = '0;
    repeat (2) @(negedge clk);
    #1;
    check("reset m_data", m_data, 32'd0);
    check("reset flags", {26'b0, m_valid, m_last, s_ready, busy, done, 1'b0}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("idle s_ready", {31'b0, s_ready}, 32'd0);

    // nearest: each sample repeated 4x
    in_vec = '{32'h1234_0100, 32'h0000_0200, 32'h8000_FF00, 32'h7FFF_0080};
    for (int i = 0; i < 16; i++) exp_vec[i] = in_vec[i/4];
    run_frame(1'b0, 1'b0, 1'b0, -1);

    // linear ramp, lane1 descending
    in_vec  = '{32'h0400_0000, 32'h0000_0100, 32'hFC00_0200, 32'hFC00_0200};
    exp_vec = '{32'h0400_0000, 32'h0300_0040, 32'h0200_0080, 32'h0100_00C0,
                32'h0000_0100, 32'hFF00_0140, 32'hFE00_0180, 32'hFD00_01C0,
                32'hFC00_0200, 32'hFC00_0200, 32'hFC00_0200, 32'hFC00_0200,
                32'hFC00_0200, 32'hFC00_0200, 32'hFC00_0200, 32'hFC00_0200};
    run_frame(1'b1, 1'b0, 1'b0, -1);
    // same frame with random stalls and an ignored mid-frame start
    run_frame(1'b1, 1'b1, 1'b1, -1);

    // linear floor rounding
    in_vec  = '{32'h0000_0000, 32'h0003_FFFF, 32'h0003_0100, 32'h0003_FF00};
    exp_vec = '{32'h0000_0000, 32'h0000_FFFF, 32'h0001_FFFF, 32'h0002_FFFF,
                32'h0003_FFFF, 32'h0003_003F, 32'h0003_007F, 32'h0003_00BF,
                32'h0003_0100, 32'h0003_0080, 32'h0003_0000, 32'h0003_FF80,
                32'h0003_FF00, 32'h0003_FF00, 32'h0003_FF00, 32'h0003_FF00};
    run_frame(1'b1, 1'b0, 1'b0, -1);

    // nearest with random stalls
    in_vec = '{32'h1234_0100, 32'h0000_0200, 32'h8000_FF00, 32'h7FFF_0080};
    for (int i = 0; i < 16; i++) exp_vec[i] = in_vec[i/4];
    run_frame(1'b0, 1'b1, 1'b0, -1);

    // reset in EMIT, then a clean frame
    run_frame(1'b0, 1'b0, 1'b0, 5);
    run_frame(1'b0, 1'b0, 1'b0, -1);

    // IN_LEN=1 linear: the single sample repeated 4x
    begin
      int b1 = 0;
      bit sent = 0;
      @(negedge clk); start1 = 1'b1; mode1 = 1'b1;
      @(negedge clk); start1 = 1'b0;
      s_data1 = 32'hFD00_0300; m_ready1 = 1'b1;
      for (int c = 0; c < 30 && b1 < 4; c++) begin
        @(negedge clk);
        s_valid1 = !sent;
        #1;
        if (m_valid1 && m_ready1) begin
          check($sformatf("len1 beat%0d data", b1), m_data1, 32'hFD00_0300);
          check($sformatf("len1 beat%0d last", b1), {31'b0, m_last1}, {31'b0, b1 == 3});
          b1++;
        end
        if (s_valid1 && s_ready1) sent = 1;
      end
      s_valid1 = 1'b0;
      if (b1 < 4) check("len1 timeout beats", b1, 4);
      @(negedge clk); #1;
      check("len1 done", {31'b0, done1}, 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
